// File: rtl/ab_seq_ctrl_pkg.sv
// ab_seq_ctrl shared types.
// State codes are also used to decode state_o in debug views.
package ab_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT_A = 3'd1,
      S_WAIT_B = 3'd2,
      S_WAIT_C = 3'd3,
      S_DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/ab_seq_ctrl_seq_delay_cnt.sv
// seq_delay_cnt: delay/timeout counter with sync clear,
// enable and terminal compare.
module seq_delay_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             hit
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + ONE;
      end
   end

   assign hit = (cnt == term);

endmodule

// File: rtl/ab_seq_ctrl.sv
// ab_seq_ctrl: drives detector a/b with programmed delays,
// then waits a bounded time for c and reports pass.
module ab_seq_ctrl
   import ab_seq_ctrl_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int DLY_A   = 3,
   parameter int DLY_B   = 2,
   parameter int TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       c_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] state_o
);

   localparam logic [CNT_W-1:0] TERM_A = CNT_W'(DLY_A - 1);
   localparam logic [CNT_W-1:0] TERM_B = CNT_W'(DLY_B - 1);
   localparam logic [CNT_W-1:0] TERM_T = CNT_W'(TIMEOUT - 1);

   state_e           state, state_n;
   logic             a_n, b_n, pass_n;
   logic             cnt_clr, cnt_en, cnt_hit;
   logic [CNT_W-1:0] term;

   seq_delay_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .term  (term),
      .hit   (cnt_hit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         a_out <= 1'b0;
         b_out <= 1'b0;
         pass  <= 1'b0;
      end else begin
         state <= state_n;
         a_out <= a_n;
         b_out <= b_n;
         pass  <= pass_n;
      end
   end

   always_comb begin
      state_n = state;
      a_n     = a_out;
      b_n     = b_out;
      pass_n  = pass;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      term    = TERM_A;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               state_n = S_WAIT_A;
               cnt_clr = 1'b1;
               pass_n  = 1'b0;
            end
         end
         S_WAIT_A: begin
            term = TERM_A;
            if (cnt_hit) begin
               state_n = S_WAIT_B;
               a_n     = 1'b1;
               cnt_clr = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_WAIT_B: begin
            term = TERM_B;
            if (cnt_hit) begin
               state_n = S_WAIT_C;
               b_n     = 1'b1;
               cnt_clr = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_WAIT_C: begin
            term = TERM_T;
            if (c_in || cnt_hit) begin
               state_n = S_DONE;
               pass_n  = c_in;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            a_n     = 1'b0;
            b_n     = 1'b0;
            cnt_clr = 1'b1;
         end
         default: begin
            state_n = S_IDLE;
            a_n     = 1'b0;
            b_n     = 1'b0;
            cnt_clr = 1'b1;
         end
      endcase
      // abort wins over hit/timeout but leaves the last result
      if (abort && state != S_IDLE) begin
         state_n = S_IDLE;
         a_n     = 1'b0;
         b_n     = 1'b0;
         pass_n  = pass;
         cnt_clr = 1'b1;
         cnt_en  = 1'b0;
      end
   end

   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);
   assign state_o = state;

endmodule
